// File: rtl/cicero_job_sequencer.sv
// Job front-end for AXI_top: loads code and string words, starts the matcher,
// waits for completion, reads the elapsed-clock counter and returns the verdict.
module cicero_job_sequencer #(
  parameter int unsigned CC_ID_BITS     = 2,
  parameter int unsigned LEN_BITS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned REG_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [LEN_BITS-1:0]  job_code_words,
  input  logic [LEN_BITS-1:0]  job_string_bytes,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_data,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] data_in_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [REG_WIDTH-1:0] data_o_register,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_accepted,
  output logic                 res_error,
  output logic [REG_WIDTH-1:0] res_cycles
);

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(5);
  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING         = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED        = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED        = REG_WIDTH'(3);

  localparam int unsigned ALIGN = ((32'd1 << CC_ID_BITS) > 32'd4) ? (32'd1 << CC_ID_BITS) : 32'd4;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SETUP, S_WR_CMD, S_WR_NOP, S_START_SETUP, S_START_CMD,
    S_START_CHECK, S_WAIT, S_READ_CC, S_READ_DONE, S_RESULT
  } state_t;

  state_t state_q, state_d;
  logic [REG_WIDTH-1:0] waddr_q, waddr_d, rem_q, rem_d;
  logic [REG_WIDTH-1:0] str_words_q, str_words_d, str_base_q, str_base_d, str_bytes_q, str_bytes_d;
  logic                 str_phase_q, str_phase_d, hold_q, hold_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic                 job_ready_d, in_ready_d, res_valid_d, res_accepted_d, res_error_d;
  logic [REG_WIDTH-1:0] addr_d, wdata_d, start_ptr_d, end_ptr_d, cmd_d, res_cycles_d;
  logic [REG_WIDTH-1:0] base_c, words_c;

  // String region starts at the first aligned byte address after the code words
  assign base_c  = ((REG_WIDTH'(job_code_words) << 2) + REG_WIDTH'(ALIGN - 1)) & ~REG_WIDTH'(ALIGN - 1);
  assign words_c = (REG_WIDTH'(job_string_bytes) + REG_WIDTH'(3)) >> 2;

  always_comb begin
    state_d        = state_q;
    waddr_d        = waddr_q;
    rem_d          = rem_q;
    str_words_d    = str_words_q;
    str_base_d     = str_base_q;
    str_bytes_d    = str_bytes_q;
    str_phase_d    = str_phase_q;
    hold_d         = 1'b0;
    tmo_d          = tmo_q;
    job_ready_d    = 1'b0;
    in_ready_d     = 1'b0;
    cmd_d          = CMD_NOP;
    res_valid_d    = 1'b0;
    res_accepted_d = res_accepted;
    res_error_d    = res_error;
    res_cycles_d   = res_cycles;
    addr_d         = address_register;
    wdata_d        = data_in_register;
    start_ptr_d    = start_cc_pointer_register;
    end_ptr_d      = end_cc_pointer_register;

    unique case (state_q)
      S_IDLE: begin
        job_ready_d = 1'b1;
        if (job_valid && job_ready) begin
          job_ready_d    = 1'b0;
          str_base_d     = base_c;
          str_words_d    = words_c;
          str_bytes_d    = REG_WIDTH'(job_string_bytes);
          waddr_d        = '0;
          res_accepted_d = 1'b0;
          res_error_d    = 1'b0;
          res_cycles_d   = '0;
          if (job_string_bytes == '0) begin
            state_d     = S_RESULT;
            res_valid_d = 1'b1;
            res_error_d = 1'b1;
          end else if (job_code_words == '0) begin
            state_d     = S_WR_SETUP;
            in_ready_d  = 1'b1;
            str_phase_d = 1'b1;
            rem_d       = words_c;
            waddr_d     = base_c >> 2;
          end else begin
            state_d     = S_WR_SETUP;
            in_ready_d  = 1'b1;
            str_phase_d = 1'b0;
            rem_d       = REG_WIDTH'(job_code_words);
          end
        end
      end
      S_WR_SETUP: begin
        in_ready_d = 1'b1;
        if (in_valid) begin
          addr_d     = waddr_q;
          wdata_d    = in_data;
          cmd_d      = CMD_WRITE;
          in_ready_d = 1'b0;
          state_d    = S_WR_CMD;
        end
      end
      S_WR_CMD: state_d = S_WR_NOP;
      S_WR_NOP: begin
        waddr_d    = waddr_q + REG_WIDTH'(1);
        rem_d      = rem_q - REG_WIDTH'(1);
        state_d    = S_WR_SETUP;
        in_ready_d = 1'b1;
        if (rem_q == REG_WIDTH'(1)) begin
          if (!str_phase_q) begin
            // Pad words between code and string are skipped, not written
            str_phase_d = 1'b1;
            rem_d       = str_words_q;
            waddr_d     = str_base_q >> 2;
          end else begin
            state_d     = S_START_SETUP;
            in_ready_d  = 1'b0;
            start_ptr_d = str_base_q;
            end_ptr_d   = str_base_q + str_bytes_q - REG_WIDTH'(1);
          end
        end
      end
      S_START_SETUP: begin
        cmd_d   = CMD_START;
        state_d = S_START_CMD;
      end
      S_START_CMD: begin
        if (!hold_q) begin
          cmd_d  = CMD_START;
          hold_d = 1'b1;
        end else begin
          state_d = S_START_CHECK;
        end
      end
      S_START_CHECK: begin
        if (status_register != STATUS_RUNNING) res_error_d = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (status_register != STATUS_RUNNING) begin
          state_d        = S_READ_CC;
          cmd_d          = CMD_READ_ELAPSED_CLOCK;
          res_accepted_d = (status_register == STATUS_ACCEPTED);
          if (status_register != STATUS_ACCEPTED && status_register != STATUS_REJECTED)
            res_error_d = 1'b1;
        end else if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
          state_d        = S_READ_CC;
          cmd_d          = CMD_READ_ELAPSED_CLOCK;
          res_accepted_d = 1'b0;
          res_error_d    = 1'b1;
        end
      end
      S_READ_CC: state_d = S_READ_DONE;
      S_READ_DONE: begin
        res_cycles_d = data_o_register;
        res_valid_d  = 1'b1;
        state_d      = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          job_ready_d = 1'b1;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q                   <= S_IDLE;
      waddr_q                   <= '0;
      rem_q                     <= '0;
      str_words_q               <= '0;
      str_base_q                <= '0;
      str_bytes_q               <= '0;
      str_phase_q               <= 1'b0;
      hold_q                    <= 1'b0;
      tmo_q                     <= '0;
      job_ready                 <= 1'b1;
      in_ready                  <= 1'b0;
      cmd_register              <= CMD_NOP;
      address_register          <= '0;
      data_in_register          <= '0;
      start_cc_pointer_register <= '0;
      end_cc_pointer_register   <= '0;
      res_valid                 <= 1'b0;
      res_accepted              <= 1'b0;
      res_error                 <= 1'b0;
      res_cycles                <= '0;
    end else begin
      state_q                   <= state_d;
      waddr_q                   <= waddr_d;
      rem_q                     <= rem_d;
      str_words_q               <= str_words_d;
      str_base_q                <= str_base_d;
      str_bytes_q               <= str_bytes_d;
      str_phase_q               <= str_phase_d;
      hold_q                    <= hold_d;
      tmo_q                     <= tmo_d;
      job_ready                 <= job_ready_d;
      in_ready                  <= in_ready_d;
      cmd_register              <= cmd_d;
      address_register          <= addr_d;
      data_in_register          <= wdata_d;
      start_cc_pointer_register <= start_ptr_d;
      end_cc_pointer_register   <= end_ptr_d;
      res_valid                 <= res_valid_d;
      res_accepted              <= res_accepted_d;
      res_error                 <= res_error_d;
      res_cycles                <= res_cycles_d;
    end
  end

endmodule

// File: tb/tb_cicero_job_sequencer.sv
// Bench for cicero_job_sequencer: two instances (4- and 16-byte string alignment)
// share stimulus and are checked against a job-level model of writes and results.
module tb_cicero_job_sequencer;

  localparam logic [31:0] CMD_NOP = 32'd0, CMD_WRITE = 32'd1, CMD_START = 32'd2, CMD_READ = 32'd5;
  localparam logic [31:0] ST_IDLE = 32'd0, ST_RUNNING = 32'd1, ST_ACCEPTED = 32'd2, ST_REJECTED = 32'd3;
  localparam int TMO = 100;
  localparam int CC_A = 2, CC_B = 4;

  logic clk = 1'b0;
  logic rst;
  logic job_valid, in_valid, res_ready;
  logic [15:0] job_code_words, job_string_bytes;
  logic [31:0] in_data, status, data_o;

  logic        job_ready_o [2], in_ready_o [2], res_valid_o [2], res_acc_o [2], res_err_o [2];
  logic [31:0] addr_o [2], wdata_o [2], start_o [2], end_o [2], cmd_o [2], res_cyc_o [2];

  always #5 clk = ~clk;

  cicero_job_sequencer #(.CC_ID_BITS(CC_A), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready_o[0]),
    .job_code_words(job_code_words), .job_string_bytes(job_string_bytes),
    .in_valid(in_valid), .in_ready(in_ready_o[0]), .in_data(in_data),
    .address_register(addr_o[0]), .data_in_register(wdata_o[0]),
    .start_cc_pointer_register(start_o[0]), .end_cc_pointer_register(end_o[0]),
    .cmd_register(cmd_o[0]), .status_register(status), .data_o_register(data_o),
    .res_valid(res_valid_o[0]), .res_ready(res_ready), .res_accepted(res_acc_o[0]),
    .res_error(res_err_o[0]), .res_cycles(res_cyc_o[0]));

  cicero_job_sequencer #(.CC_ID_BITS(CC_B), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready_o[1]),
    .job_code_words(job_code_words), .job_string_bytes(job_string_bytes),
    .in_valid(in_valid), .in_ready(in_ready_o[1]), .in_data(in_data),
    .address_register(addr_o[1]), .data_in_register(wdata_o[1]),
    .start_cc_pointer_register(start_o[1]), .end_cc_pointer_register(end_o[1]),
    .cmd_register(cmd_o[1]), .status_register(status), .data_o_register(data_o),
    .res_valid(res_valid_o[1]), .res_ready(res_ready), .res_accepted(res_acc_o[1]),
    .res_error(res_err_o[1]), .res_cycles(res_cyc_o[1]));

  int checks = 0;
  int failures = 0;
  int job_id = 0;
  int cyc = 0;
  bit chk_tmo = 0;

  typedef logic [63:0] wq_t [$];
  wq_t expq [2];
  logic [31:0] exp_start [2], exp_end [2], exp_base [2], last_waddr [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int jid, input int idx, input bit is_str);
    return {(is_str ? 8'h5A : 8'hC0), 8'(jid), 16'(idx)};
  endfunction

  // Job-level model: which word lands at which address, and where the string sits
  task automatic build_model(input int cw, input int nbytes);
    int sw;
    sw = (nbytes + 3) / 4;
    for (int k = 0; k < 2; k++) begin
      int al, base, cc;
      cc = (k == 0) ? CC_A : CC_B;
      al = ((1 << cc) < 4) ? 4 : (1 << cc);
      base = ((4 * cw + al - 1) / al) * al;
      exp_base[k] = 32'(base);
      expq[k].delete();
      if (nbytes > 0) begin
        for (int i = 0; i < cw; i++) expq[k].push_back({32'(i), word_of(job_id, i, 1'b0)});
        for (int j = 0; j < sw; j++) expq[k].push_back({32'(base / 4 + j), word_of(job_id, j, 1'b1)});
        exp_start[k] = 32'(base);
        exp_end[k]   = 32'(base + nbytes - 1);
      end
    end
  endtask

  task automatic send_job(input int cw, input int nbytes);
    bit got;
    got = 0;
    job_code_words = 16'(cw);
    job_string_bytes = 16'(nbytes);
    job_valid = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      if (job_ready_o[0]) got = 1;
      @(negedge clk);
    end
    job_valid = 1'b0;
    chk("job_accept", 32'(got), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int stall);
    bit got;
    got = 0;
    in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    in_valid = 1'b1;
    in_data = w;
    for (int t = 0; t < 50 && !got; t++) begin
      if (in_ready_o[0]) got = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("word_accept", 32'(got), 32'd1);
  endtask

  // scen: 0 accept, 1 reject, 2 never running, 3 stuck running
  task automatic run_job(input int cw, input int nbytes, input int scen, input int stall,
                         input int bp, input logic [31:0] cyc_val, input logic exp_acc, input logic exp_err);
    int sw;
    bit got;
    logic [31:0] exp_cyc;
    job_id++;
    sw = (nbytes + 3) / 4;
    exp_cyc = (nbytes == 0) ? 32'd0 : cyc_val;
    status = ST_IDLE;
    data_o = cyc_val;
    chk_tmo = (scen == 3);
    build_model(cw, nbytes);
    res_ready = (bp == 0);
    send_job(cw, nbytes);
    if (nbytes > 0) begin
      for (int i = 0; i < cw + sw; i++)
        send_word((i < cw) ? word_of(job_id, i, 1'b0) : word_of(job_id, i - cw, 1'b1), (i > 0) ? stall : 0);
      got = 0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk);
        if (cmd_o[0] == CMD_START) got = 1;
      end
      chk("start_seen", 32'(got), 32'd1);
      if (scen != 2) status = ST_RUNNING;
      if (scen < 2) begin
        repeat (5) @(negedge clk);
        status = (scen == 0) ? ST_ACCEPTED : ST_REJECTED;
      end
    end
    got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      if (res_valid_o[0]) got = 1;
      else @(negedge clk);
    end
    chk("res_valid_seen", 32'(got), 32'd1);
    for (int k = 0; k < 2; k++) begin
      chk("res_accepted", 32'(res_acc_o[k]), 32'(exp_acc));
      chk("res_error", 32'(res_err_o[k]), 32'(exp_err));
      chk("res_cycles", res_cyc_o[k], exp_cyc);
      chk("writes_outstanding", 32'(expq[k].size()), 32'd0);
    end
    if (bp > 0) begin
      repeat (bp) begin
        @(negedge clk);
        chk("res_valid_held", 32'(res_valid_o[0]), 32'd1);
      end
      res_ready = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("res_valid_after_hs", 32'(res_valid_o[k]), 32'd0);
      chk("job_ready_after_hs", 32'(job_ready_o[k]), 32'd1);
    end
    res_ready = 1'b0;
    status = ST_IDLE;
    chk_tmo = 0;
  endtask

  // Per-cycle protocol and write-stream checks against the model
  logic [31:0] prev_cmd [2];
  logic        prev_rv [2], prev_acc [2], prev_err [2];
  logic [31:0] prev_cyc [2];
  int          start_cnt [2], start_cyc [2];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        prev_cmd[k] = CMD_NOP;
        prev_rv[k] = 1'b0;
        start_cnt[k] = 0;
      end else begin
        if (in_ready_o[k]) begin
          chk("in_ready_with_job_ready", 32'(job_ready_o[k]), 32'd0);
          chk("setup_cmd_nop", cmd_o[k], CMD_NOP);
        end
        if (cmd_o[k] == CMD_WRITE) begin
          chk("write_pulse_len", 32'(prev_cmd[k] == CMD_WRITE), 32'd0);
          if (expq[k].size() == 0) chk("write_expected_count", 32'd0, 32'd1);
          else begin
            logic [63:0] e;
            e = expq[k].pop_front();
            chk("write_addr", addr_o[k], e[63:32]);
            chk("write_data", wdata_o[k], e[31:0]);
            last_waddr[k] = addr_o[k];
          end
        end
        if (cmd_o[k] == CMD_START) begin
          if (prev_cmd[k] != CMD_START) begin
            start_cnt[k] = 1;
            start_cyc[k] = cyc;
            chk("start_ptr", start_o[k], exp_start[k]);
            chk("end_ptr", end_o[k], exp_end[k]);
          end else start_cnt[k]++;
        end else if (prev_cmd[k] == CMD_START) begin
          chk("start_len", 32'(start_cnt[k]), 32'd2);
        end
        if (cmd_o[k] == CMD_READ) begin
          chk("read_pulse_len", 32'(prev_cmd[k] == CMD_READ), 32'd0);
          if (prev_cmd[k] != CMD_READ && chk_tmo)
            chk("timeout_span", 32'(cyc - start_cyc[k]), 32'(TMO + 3));
        end
        if (res_valid_o[k]) begin
          chk("job_ready_in_result", 32'(job_ready_o[k]), 32'd0);
          if (prev_rv[k]) begin
            chk("res_acc_stable", 32'(res_acc_o[k]), 32'(prev_acc[k]));
            chk("res_err_stable", 32'(res_err_o[k]), 32'(prev_err[k]));
            chk("res_cyc_stable", res_cyc_o[k], prev_cyc[k]);
          end
        end
        prev_cmd[k] = cmd_o[k];
        prev_rv[k]  = res_valid_o[k];
        prev_acc[k] = res_acc_o[k];
        prev_err[k] = res_err_o[k];
        prev_cyc[k] = res_cyc_o[k];
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    job_valid = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    job_code_words = '0; job_string_bytes = '0;
    in_data = '0; status = ST_IDLE; data_o = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cmd", cmd_o[k], CMD_NOP);
      chk("rst_job_ready", 32'(job_ready_o[k]), 32'd1);
      chk("rst_in_ready", 32'(in_ready_o[k]), 32'd0);
      chk("rst_res_valid", 32'(res_valid_o[k]), 32'd0);
      chk("rst_addr", addr_o[k], 32'd0);
      chk("rst_start_ptr", start_o[k], 32'd0);
      chk("rst_res_cycles", res_cyc_o[k], 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    run_job(3, 5, 0, 0, 0, 32'd37, 1'b1, 1'b0);
    chk("job1_model_base_a", exp_base[0], 32'd12);
    chk("job1_start_ptr_a", start_o[0], 32'd12);
    chk("job1_end_ptr_a", end_o[0], 32'd16);
    chk("job1_last_waddr_a", last_waddr[0], 32'd4);

    run_job(5, 6, 1, 0, 0, 32'd52, 1'b0, 1'b0);
    chk("job2_model_base_b", exp_base[1], 32'd32);
    chk("job2_start_ptr_b", start_o[1], 32'd32);
    chk("job2_last_waddr_b", last_waddr[1], 32'd9);
    chk("job2_last_waddr_a", last_waddr[0], 32'd6);

    run_job(2, 9, 0, 4, 0, 32'd100, 1'b1, 1'b0);
    run_job(4, 0, 0, 0, 0, 32'd55, 1'b0, 1'b1);
    run_job(1, 4, 2, 0, 0, 32'd7, 1'b0, 1'b1);
    run_job(2, 3, 3, 0, 0, 32'd9, 1'b0, 1'b1);

    // Reset asserted while the second string word's write command is on the bus
    job_id++;
    status = ST_IDLE;
    build_model(3, 12);
    send_job(3, 12);
    for (int i = 0; i < 5; i++)
      send_word((i < 3) ? word_of(job_id, i, 1'b0) : word_of(job_id, i - 3, 1'b1), 0);
    chk("pre_reset_cmd_write", cmd_o[0], CMD_WRITE);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("midrst_cmd", cmd_o[k], CMD_NOP);
      chk("midrst_job_ready", 32'(job_ready_o[k]), 32'd1);
      chk("midrst_in_ready", 32'(in_ready_o[k]), 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) expq[k].delete();
    repeat (4) @(negedge clk);
    chk("post_reset_idle", 32'(job_ready_o[0]), 32'd1);

    run_job(3, 5, 0, 0, 0, 32'd37, 1'b1, 1'b0);
    run_job(0, 4, 0, 0, 10, 32'd21, 1'b1, 1'b0);
    chk("job9_start_ptr_b", start_o[1], 32'd0);
    chk("job9_end_ptr_b", end_o[1], 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cicero_job_sequencer.md
Name: cicero_job_sequencer

Overview:
- Hardware front-end that drives the AXI_top register interface (address/data/cmd/start/end pointers, status, data_o) from a streamed job.
- One job is a descriptor followed by a word stream. The block performs these steps in order:
  1. Load the code words.
  2. Load the string words at an aligned address.
  3. Issue CMD_START and wait for completion.
  4. Read the elapsed-clock counter.
  5. Return accept/reject plus the cycle count on a result handshake.
- It replaces the software/bench register sequencing that sits upstream of AXI_top.

Parameters:
- CC_ID_BITS, 2: string start byte address aligned to max(4, 2**CC_ID_BITS) bytes.
- LEN_BITS, 16: width of the descriptor length fields.
- TIMEOUT_CYCLES, 1_000_000: maximum number of WAIT cycles before the job aborts with an error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- job_valid  in  1  descriptor valid.
- job_ready  out  1  descriptor accepted; high only in IDLE.
- job_code_words  in  LEN_BITS  number of 32-bit code words (2 instructions each).
- job_string_bytes  in  LEN_BITS  string length in bytes.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream word accepted.
- in_data  in  REG_WIDTH  code words first, then string words (byte0 in [7:0]).
- address_register  out  REG_WIDTH  word address to AXI_top.
- data_in_register  out  REG_WIDTH  write data.
- start_cc_pointer_register  out  REG_WIDTH  string start byte address.
- end_cc_pointer_register  out  REG_WIDTH  last string byte address.
- cmd_register  out  REG_WIDTH  CMD_* from AXI_package.
- status_register  in  REG_WIDTH  STATUS_* from AXI_package.
- data_o_register  in  REG_WIDTH  read data.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_accepted  out  1  1 if STATUS_ACCEPTED.
- res_error  out  1  protocol error, timeout, or zero-length string.
- res_cycles  out  REG_WIDTH  elapsed clock value read back.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - cmd_register=CMD_NOP; all other register outputs, res_*, and in_ready are 0; job_ready=1.
  - A reset mid-job drops the job immediately. The next cycle drives CMD_NOP and no further writes are issued.
- IDLE:
  - On job_valid&&job_ready, latch both lengths and set waddr=0.
  - Compute the string start: str_base = align_up(4*code_words, max(4, 2**CC_ID_BITS)).
  - Compute str_words = ceil(string_bytes/4). Widths are REG_WIDTH; there is no overflow check.
  - If string_bytes==0, go to RESULT with res_error=1, res_accepted=0, res_cycles=0. Any code words are not consumed.
  - Otherwise go to WR_SETUP, or skip the code phase if code_words==0.
- Write transaction (per word, 3 cycles minimum):
  - WR_SETUP: in_ready=1. On in_valid, set address_register<=waddr and data_in_register<=in_data, then go to WR_CMD. Without in_valid, stay, with cmd=CMD_NOP.
  - WR_CMD: cmd_register=CMD_WRITE for exactly 1 cycle.
  - WR_NOP: cmd_register=CMD_NOP, then waddr+=1.
  - After code_words writes, set waddr=str_base>>2. Pad gap words are not written.
  - After str_words string writes, go to START_SETUP.
  - Bytes past string_bytes in the last word are written as received.
- START_SETUP: start_cc_pointer_register=str_base; end_cc_pointer_register=str_base+string_bytes-1.
- START_CMD: cmd=CMD_START held for 2 cycles.
- START_CHECK:
  - Sample status_register. If it is not STATUS_RUNNING, set the error flag.
  - Set cmd=CMD_NOP and go to WAIT.
- WAIT:
  - Increment the timeout counter each cycle.
  - Exit when status_register is not STATUS_RUNNING.
  - If the counter hits TIMEOUT_CYCLES, set the error flag and exit.
  - On exit: accepted = (status==STATUS_ACCEPTED). Set the error flag if status is neither ACCEPTED nor REJECTED (timeout excepted).
- READ_CC: cmd=CMD_READ_ELAPSED_CLOCK for 1 cycle. The next cycle samples data_o_register into res_cycles and drives CMD_NOP.
- RESULT:
  - res_valid=1 with stable res_* until res_ready; go to IDLE on the handshake.
  - res_ready held high in advance completes in the first RESULT cycle.
- Simultaneous events: job_ready is 0 outside IDLE. in_ready is only high in WR_SETUP and is never high in the same cycle as job_ready.

Test Plan:
- code_words=3, string_bytes=5, CC_ID_BITS=2:
  - Writes to word addresses 0,1,2 then 3,4; 5 CMD_WRITE pulses of 1 cycle each.
  - start=12, end=16. Bench drives RUNNING then ACCEPTED, data_o=37 → res_accepted=1, res_error=0, res_cycles=37.
- CC_ID_BITS=4, code_words=5:
  - str_base=32; first string write at address 8; no writes to addresses 5..7.
  - Status REJECTED → res_accepted=0.
- Stalls: in_valid deasserted for 4 cycles between words → cmd stays NOP, no duplicate or missing writes, data order preserved.
- Faults:
  - string_bytes=0 → res_error=1 with no writes.
  - Status never RUNNING after START → res_error=1.
  - TIMEOUT_CYCLES=100 with status stuck RUNNING → res_error=1 after 100 WAIT cycles.
- Reset mid-run: rst low during the 2nd string WR_CMD → next cycle cmd=CMD_NOP, job_ready=1; a fresh job then completes normally.
- Back-pressure: res_ready low for 10 cycles → res_valid and res_* stable; job_ready=0 until the handshake.
